// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of one state per cycle; lw 5, sw/R/addi 4, beq/j 3 cycles.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready, aborting to FETCH after MAX_WAIT idle cycles; BYTE_OPS_EN adds lb/sb.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int STATE_W  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       byte_enable,
  output logic       illegal_op,
  output logic       mem_err
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st, timeout, op_legal;
  logic             pcwrite, branch;

  assign wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout = (MAX_WAIT > 0) && wait_st && !mem_ready &&
                   (wait_cnt == CNT_W'(MAX_WAIT));

  always_comb begin
    state_nxt = state;
    op_legal  = 1'b1;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RT:        state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
`ifdef BYTE_OPS_EN
          OP_LB, OP_SB: state_nxt = MEMADR;
`endif
          default: begin
            state_nxt = FETCH;
            op_legal  = 1'b0;
          end
        endcase
      end
      // op[3] separates stores (sw/sb) from loads (lw/lb); IR is stable here
      MEMADR:  state_nxt = op[3] ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_nxt = MEMWB;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   if (mem_ready) state_nxt = FETCH;
      EXECUTE: state_nxt = ALUWB;
      ALUWB:   state_nxt = FETCH;
      BRANCH:  state_nxt = FETCH;
      ADDIEX:  state_nxt = ADDIWB;
      ADDIWB:  state_nxt = FETCH;
      JUMP:    state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
    if (timeout) state_nxt = FETCH;
  end

`ifdef BYTE_OPS_EN
  logic byte_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
`ifdef BYTE_OPS_EN
      byte_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state || timeout)
        wait_cnt <= '0;
      else if (MAX_WAIT > 0 && wait_st && !mem_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
`ifdef BYTE_OPS_EN
      if (state == DECODE) byte_q <= (op == OP_LB) || (op == OP_SB);
`endif
    end
  end

  always_comb begin
    pcwrite     = 1'b0;
    branch      = 1'b0;
    pcen        = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = 2'b00;
    byte_enable = 1'b0;
    case (state)
      FETCH:   begin alusrcb = 2'b01; irwrite = mem_ready; pcwrite = mem_ready; end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      EXECUTE: begin alusrca = 1'b1; aluop = 2'b10; end
      ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; end
      BRANCH:  begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  regwrite = 1'b1;
      JUMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
`ifdef BYTE_OPS_EN
    byte_enable = byte_q && ((state == MEMADR) || (state == MEMRD) ||
                             (state == MEMWB)  || (state == MEMWR));
`endif
    pcen = pcwrite | (branch & zero);
    // Reset or a timed-out access must leave no architectural write behind
    if (!reset_n || timeout) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign illegal_op = reset_n && (state == DECODE) && !op_legal;
  assign mem_err    = reset_n && timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboarded bench for multicycle_ctrl (MAX_WAIT=4): per-cycle expected control words queued by the driver.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, zero, mem_ready;
  logic [5:0] op;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       byte_enable, illegal_op, mem_err;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(4), .STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .byte_enable(byte_enable),
    .illegal_op(illegal_op), .mem_err(mem_err)
  );

  wire [16:0] obs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, aluop, byte_enable, illegal_op, mem_err};

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_WR = 5;
  localparam int S_EX = 6, S_AWB = 7, S_BR = 8, S_AIE = 9, S_AIW = 10, S_J = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111, LB = 6'b100000;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", tag, got, want);
    end
  endtask

  // Control word expected in a given state, from the per-state output table
  function automatic logic [16:0] ew(input int st, input bit mr, input bit zr, input bit ill,
                                     input bit tmo, input bit be, input bit rl);
    logic pce, io, mw, irw, rd, m2r, rw, sa, bye;
    logic [1:0] sb, ps, ao;
    {pce, io, mw, irw, rd, m2r, rw, sa, bye} = '0;
    {sb, ps, ao} = '0;
    case (st)
      S_F:   begin sb = 2'b01; irw = mr; pce = mr; end
      S_D:   sb = 2'b11;
      S_MA:  begin sa = 1; sb = 2'b10; bye = be; end
      S_MR:  begin io = 1; bye = be; end
      S_MWB: begin m2r = 1; rw = 1; bye = be; end
      S_WR:  begin io = 1; mw = 1; bye = be; end
      S_EX:  begin sa = 1; ao = 2'b10; end
      S_AWB: begin rd = 1; rw = 1; end
      S_BR:  begin sa = 1; ao = 2'b01; ps = 2'b01; pce = zr; end
      S_AIE: begin sa = 1; sb = 2'b10; end
      S_AIW: rw = 1;
      S_J:   begin ps = 2'b10; pce = 1; end
      default: ;
    endcase
    if (rl || tmo) {pce, irw, mw, rw} = '0;
    return {pce, io, mw, irw, rd, m2r, rw, sa, sb, ps, ao, bye, ill, tmo};
  endfunction

  task automatic step(input string tag, input bit rn, input logic [5:0] opv, input bit mr,
                      input bit zr, input logic [16:0] w);
    @(negedge clk);
    reset_n = rn; op = opv; mem_ready = mr; zero = zr;
    exp_q.push_back(w);
    tag_q.push_back(tag);
  endtask

  // Shorthand for a normal (reset released, no timeout, no byte) cycle
  task automatic st(input string tag, input logic [5:0] opv, input int s, input bit mr,
                    input bit zr, input bit ill);
    step(tag, 1'b1, opv, mr, zr, ew(s, mr, zr, ill, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0; op = RT; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 2; i++) step("reset", 1'b0, RT, 1'b1, 1'b0, ew(S_F, 1, 0, 0, 0, 0, 1));

    st("lw_f", LW, S_F, 1, 0, 0); st("lw_d", LW, S_D, 1, 0, 0);
    st("lw_ma", LW, S_MA, 1, 0, 0); st("lw_mr", LW, S_MR, 1, 0, 0);
    st("lw_wb", LW, S_MWB, 1, 0, 0);

    st("sw_f", SW, S_F, 1, 0, 0); st("sw_d", SW, S_D, 1, 0, 0); st("sw_ma", SW, S_MA, 1, 0, 0);
    for (int i = 0; i < 3; i++) st("sw_wr_wait", SW, S_WR, 0, 0, 0);
    st("sw_wr_done", SW, S_WR, 1, 0, 0);

    st("rt_f", RT, S_F, 1, 0, 0); st("rt_d", RT, S_D, 1, 0, 0);
    st("rt_ex", RT, S_EX, 1, 0, 0); st("rt_wb", RT, S_AWB, 1, 0, 0);

    st("addi_f", ADDI, S_F, 1, 0, 0); st("addi_d", ADDI, S_D, 1, 0, 0);
    st("addi_ex", ADDI, S_AIE, 1, 0, 0); st("addi_wb", ADDI, S_AIW, 1, 0, 0);

    st("beq1_f", BEQ, S_F, 1, 0, 0); st("beq1_d", BEQ, S_D, 1, 0, 0);
    st("beq1_br", BEQ, S_BR, 1, 1, 0);
    st("beq0_f", BEQ, S_F, 1, 0, 0); st("beq0_d", BEQ, S_D, 1, 0, 0);
    st("beq0_br", BEQ, S_BR, 1, 0, 0);

    st("j_f", JMP, S_F, 1, 0, 0); st("j_d", JMP, S_D, 1, 0, 0); st("j_j", JMP, S_J, 1, 0, 0);

    st("ill_f", BAD, S_F, 1, 0, 0); st("ill_d", BAD, S_D, 1, 0, 1);

`ifdef BYTE_OPS_EN
    st("lb_f", LB, S_F, 1, 0, 0); st("lb_d", LB, S_D, 1, 0, 0);
    step("lb_ma", 1'b1, LB, 1, 0, ew(S_MA, 1, 0, 0, 0, 1, 0));
    step("lb_mr", 1'b1, LB, 1, 0, ew(S_MR, 1, 0, 0, 0, 1, 0));
    step("lb_wb", 1'b1, LB, 1, 0, ew(S_MWB, 1, 0, 0, 0, 1, 0));
`else
    st("lb_f", LB, S_F, 1, 0, 0); st("lb_ill", LB, S_D, 1, 0, 1);
`endif

    // Ready arriving exactly when the counter hits the limit completes normally
    st("lwb_f", LW, S_F, 1, 0, 0); st("lwb_d", LW, S_D, 1, 0, 0); st("lwb_ma", LW, S_MA, 1, 0, 0);
    for (int i = 0; i < 4; i++) st("lwb_mr_wait", LW, S_MR, 0, 0, 0);
    st("lwb_mr_edge", LW, S_MR, 1, 0, 0); st("lwb_wb", LW, S_MWB, 1, 0, 0);

    for (int i = 0; i < 4; i++) st("to_wait", JMP, S_F, 0, 0, 0);
    step("to_err", 1'b1, JMP, 0, 0, ew(S_F, 0, 0, 0, 1, 0, 0));
    st("to_refetch", JMP, S_F, 1, 0, 0); st("to_d", JMP, S_D, 1, 0, 0);
    st("to_j", JMP, S_J, 1, 0, 0);

    st("ab_f", LW, S_F, 1, 0, 0); st("ab_d", LW, S_D, 1, 0, 0); st("ab_ma", LW, S_MA, 1, 0, 0);
    st("ab_mr", LW, S_MR, 0, 0, 0);
    step("ab_reset", 1'b0, LW, 1, 0, ew(S_F, 1, 0, 0, 0, 0, 1));
    st("ab_f2", LW, S_F, 1, 0, 0); st("ab_d2", LW, S_D, 1, 0, 0);
    st("ab_ma2", LW, S_MA, 1, 0, 0); st("ab_mr2", LW, S_MR, 1, 0, 0);
    st("ab_wb2", LW, S_MWB, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
